// File: rtl/trig_lut_unit_pkg.sv
// Shared definitions for the trigonometric LUT engine.
//   - function-select encodings, angle constants, IEEE-754 double constants
//   - FSM state encoding
//   - elaboration-time helpers that build the first-quadrant sin/tan tables.
//     The helpers use real arithmetic and are evaluated only as constants.
package trig_lut_unit_pkg;

    localparam logic [1:0] TRIG_SIN = 2'b00;
    localparam logic [1:0] TRIG_COS = 2'b01;
    localparam logic [1:0] TRIG_TAN = 2'b10;
    localparam logic [1:0] TRIG_COT = 2'b11;

    localparam int unsigned DEG_90  = 90;
    localparam int unsigned DEG_360 = 360;

    localparam logic [63:0] DBL_POS_INF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] DBL_ONE     = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] DBL_HALF    = 64'h3FE0_0000_0000_0000;

    // One entry per degree, 0..90 inclusive.
    localparam int unsigned ROM_DEPTH = DEG_90 + 1;
    localparam int unsigned ROM_AW    = 7;

    typedef enum logic [2:0] {
        StIdle,
        StReduce,
        StLookup,
        StAdjust,
        StDone
    } trig_state_e;

    localparam real TRIG_PI = 3.14159265358979323846;

    function automatic real sin_series(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real cos_series(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / $itor((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Exactly representable points are pinned so that series rounding
    // can never disturb them.
    function automatic logic [63:0] sin_bits(input int deg);
        real x;
        logic [63:0] res;
        x = $itor(deg) * TRIG_PI / 180.0;
        if (deg == 0) begin
            res = 64'h0;
        end else if (deg == 30) begin
            res = DBL_HALF;
        end else if (deg == 90) begin
            res = DBL_ONE;
        end else begin
            res = $realtobits(sin_series(x));
        end
        return res;
    endfunction

    function automatic logic [63:0] tan_bits(input int deg);
        real x;
        logic [63:0] res;
        x = $itor(deg) * TRIG_PI / 180.0;
        if (deg == 0) begin
            res = 64'h0;
        end else if (deg == 45) begin
            res = DBL_ONE;
        end else if (deg == 90) begin
            res = DBL_POS_INF;
        end else begin
            res = $realtobits(sin_series(x) / cos_series(x));
        end
        return res;
    endfunction

endpackage

// File: rtl/trig_rom_quarter.sv
// First-quadrant sin/tan ROM, 91 IEEE-754 double entries per table.
// Ports:
//   clk     rising-edge clock
//   sel_tan 0 selects the sin table, 1 selects the tan table
//   addr    degree index 0..90
//   rdata   registered table value, valid one cycle after addr/sel_tan
module trig_rom_quarter
    import trig_lut_unit_pkg::*;
(
    input  logic              clk,
    input  logic              sel_tan,
    input  logic [ROM_AW-1:0] addr,
    output logic [63:0]       rdata
);

    logic [63:0] sin_tab [ROM_DEPTH];
    logic [63:0] tan_tab [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tab
        localparam logic [63:0] SinVal = sin_bits(i);
        localparam logic [63:0] TanVal = tan_bits(i);
        assign sin_tab[i] = SinVal;
        assign tan_tab[i] = TanVal;
    end

    // Addresses above 90 cannot be generated; clamping keeps the read defined.
    logic [ROM_AW-1:0] addr_c;
    assign addr_c = (addr > ROM_AW'(DEG_90)) ? ROM_AW'(DEG_90) : addr;

    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= sel_tan ? tan_tab[addr_c] : sin_tab[addr_c];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trig_lut_unit.sv
// Multi-function (sin/cos/tan/cot) trigonometric LUT engine returning IEEE-754 doubles.
// The integer degree input is reduced modulo 360 by repeated subtraction, folded into
// the first quadrant, looked up in trig_rom_quarter and sign-corrected.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           request handshake (in_ready high only in IDLE)
//   in_angle, in_mode           unsigned degrees; 00 sin, 01 cos, 10 tan, 11 cot
//   out_valid/out_ready         result handshake
//   out_data                    double result
//   out_quadrant                quadrant of the reduced angle
//   out_err                     result is +/-inf (undefined function value)
// Optional build macro TRIG_LUT_STATS_EN adds:
//   op_count                    saturating count of completed result handshakes
//   err_count                   saturating count of those completions with out_err set
module trig_lut_unit
    import trig_lut_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ANGLE_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ANGLE_WIDTH-1:0]  in_angle,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH*2-1:0] out_data,
    output logic [1:0]              out_quadrant,
    output logic                    out_err
`ifdef TRIG_LUT_STATS_EN
    ,
    output logic [31:0]             op_count,
    output logic [15:0]             err_count
`endif
);

    // Working width must hold 360 even for narrow angle inputs.
    localparam int unsigned RedW = (ANGLE_WIDTH > 9) ? ANGLE_WIDTH : 9;

    trig_state_e       state_q, state_d;
    logic [RedW-1:0]   angle_q, angle_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        quad_q;
    logic              neg_q;
    logic [63:0]       out_data_q;
    logic [1:0]        out_quadrant_q;
    logic              out_err_q;

    logic [1:0]        lk_quad;
    logic [RedW-1:0]   lk_base;
    logic [ROM_AW-1:0] lk_r;
    logic              lk_comp;
    logic              lk_neg;
    logic [ROM_AW-1:0] rom_addr;
    logic [63:0]       rom_data;
    logic [63:0]       adj_data;
    logic              rom_inf;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    angle_d = RedW'(in_angle);
                    mode_d  = in_mode;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                if (angle_q >= RedW'(DEG_360)) begin
                    angle_d = angle_q - RedW'(DEG_360);
                end else begin
                    state_d = StLookup;
                end
            end
            StLookup: state_d = StAdjust;
            StAdjust: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Quadrant fold. sin/tan read the complement index in odd quadrants;
    // cos/cot (mode bit 0 set) read it in even quadrants.
    always_comb begin
        lk_quad = 2'd0;
        lk_base = '0;
        if (angle_q >= RedW'(3 * DEG_90)) begin
            lk_quad = 2'd3;
            lk_base = RedW'(3 * DEG_90);
        end else if (angle_q >= RedW'(2 * DEG_90)) begin
            lk_quad = 2'd2;
            lk_base = RedW'(2 * DEG_90);
        end else if (angle_q >= RedW'(DEG_90)) begin
            lk_quad = 2'd1;
            lk_base = RedW'(DEG_90);
        end
        lk_r     = ROM_AW'(angle_q - lk_base);
        lk_comp  = lk_quad[0] ^ mode_q[0];
        rom_addr = lk_comp ? (ROM_AW'(DEG_90) - lk_r) : lk_r;
        case (mode_q)
            TRIG_SIN: lk_neg = lk_quad[1];
            TRIG_COS: lk_neg = lk_quad[1] ^ lk_quad[0];
            default:  lk_neg = lk_quad[0];
        endcase
    end

    // rom_addr is stable while in LOOKUP, so rom_data is the requested entry in ADJUST.
    trig_rom_quarter u_rom (
        .clk     (clk),
        .sel_tan (mode_q[1]),
        .addr    (rom_addr),
        .rdata   (rom_data)
    );

    // A table zero never picks up the quadrant sign: result is always +0.0.
    assign rom_inf  = (rom_data == DBL_POS_INF);
    assign adj_data = (rom_data == 64'h0) ? 64'h0 : {rom_data[63] ^ neg_q, rom_data[62:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            angle_q        <= '0;
            mode_q         <= TRIG_SIN;
            quad_q         <= 2'd0;
            neg_q          <= 1'b0;
            out_data_q     <= 64'h0;
            out_quadrant_q <= 2'd0;
            out_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            mode_q  <= mode_d;
            if (state_q == StLookup) begin
                quad_q <= lk_quad;
                neg_q  <= lk_neg;
            end
            if (state_q == StAdjust) begin
                out_data_q     <= adj_data;
                out_quadrant_q <= quad_q;
                out_err_q      <= rom_inf;
            end
        end
    end

    assign out_data     = (DATA_WIDTH * 2)'(out_data_q);
    assign out_quadrant = out_quadrant_q;
    assign out_err      = out_err_q;

`ifdef TRIG_LUT_STATS_EN
    logic [31:0] op_count_q;
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q  <= '0;
            err_count_q <= '0;
        end else if (out_valid && out_ready) begin
            if (op_count_q != '1) begin
                op_count_q <= op_count_q + 32'd1;
            end
            if (out_err_q && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign op_count  = op_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_trig_lut_unit.sv
// Directed self-checking bench for trig_lut_unit.
// Latency is counted in rising edges from the accepting edge inclusive.
module tb_trig_lut_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_angle;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_quadrant;
    logic        out_err;
`ifdef TRIG_LUT_STATS_EN
    logic [31:0] op_count;
    logic [15:0] err_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trig_lut_unit #(
        .DATA_WIDTH  (32),
        .ANGLE_WIDTH (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_angle     (in_angle),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_quadrant (out_quadrant),
        .out_err      (out_err)
`ifdef TRIG_LUT_STATS_EN
        ,
        .op_count     (op_count),
        .err_count    (err_count)
`endif
    );

    // Drives one request and collects the result; called #1 after a rising edge.
    task automatic do_request(input logic [9:0] angle, input logic [1:0] mode, input bit ack,
                              output logic [63:0] data, output logic [1:0] quad,
                              output logic err, output int lat, output bit busy_ok,
                              output bit timed_out);
        int waited;
        timed_out = 1'b0;
        busy_ok   = 1'b1;
        waited    = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) timed_out = 1'b1;
        in_valid = 1'b1;
        in_angle = angle;
        in_mode  = mode;
        @(posedge clk);
        #1;
        // Inputs change while busy; the block must ignore them.
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_angle = 10'd0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) timed_out = 1'b1;
        data = out_data;
        quad = out_quadrant;
        err  = out_err;
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_angle  = 10'd0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (out_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        total++;
        if (out_quadrant !== 2'd0 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_quad_err: got q=%0d err=%b want q=0 err=0", out_quadrant, out_err);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sin30();
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        do_request(10'd30, 2'b00, 1'b1, d, q, e, lat, busy_ok, to);
        total++;
        if (to !== 1'b0) begin
            bad++;
            $display("FAIL sin30_timeout: handshake bound expired");
        end
        total++;
        if (d !== 64'h3FE0_0000_0000_0000 || q !== 2'd0 || e !== 1'b0) begin
            bad++;
            $display("FAIL sin30_result: got %h q=%0d err=%b want 3fe0000000000000 q=0 err=0",
                     d, q, e);
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL sin30_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_quadrants();
        logic [9:0]  ang   [7] = '{10'd210, 10'd60, 10'd180, 10'd45, 10'd135, 10'd0, 10'd180};
        logic [1:0]  mode  [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11};
        logic [63:0] exp_d [7] = '{64'hBFE0_0000_0000_0000, 64'h3FE0_0000_0000_0000,
                                   64'h0000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
                                   64'hBFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000,
                                   64'h7FF0_0000_0000_0000};
        logic [1:0]  exp_q [7] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
        logic        exp_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        for (int i = 0; i < 7; i++) begin
            do_request(ang[i], mode[i], 1'b1, d, q, e, lat, busy_ok, to);
            total++;
            if (to !== 1'b0 || d !== exp_d[i]) begin
                bad++;
                $display("FAIL quad_data[%0d] mode=%0d angle=%0d: got %h want %h (timeout=%b)",
                         i, mode[i], ang[i], d, exp_d[i], to);
            end
            total++;
            if (q !== exp_q[i] || e !== exp_e[i] || lat != 4) begin
                bad++;
                $display("FAIL quad_meta[%0d]: got q=%0d err=%b lat=%0d want q=%0d err=%b lat=4",
                         i, q, e, lat, exp_q[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_tan_pole();
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        do_request(10'd90, 2'b10, 1'b1, d, q, e, lat, busy_ok, to);
        total++;
        if (to !== 1'b0 || d[62:0] !== 63'h7FF0_0000_0000_0000) begin
            bad++;
            $display("FAIL tan90_magnitude: got %h want inf magnitude (timeout=%b)", d, to);
        end
        total++;
        if (e !== 1'b1 || q !== 2'd1) begin
            bad++;
            $display("FAIL tan90_err: got err=%b q=%0d want err=1 q=1", e, q);
        end
    endtask

    task automatic test_multi_wrap();
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        do_request(10'd750, 2'b00, 1'b1, d, q, e, lat, busy_ok, to);
        total++;
        if (to !== 1'b0 || d !== 64'h3FE0_0000_0000_0000 || q !== 2'd0) begin
            bad++;
            $display("FAIL sin750_result: got %h q=%0d want 3fe0000000000000 q=0", d, q);
        end
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL sin750_latency: got %0d want 6", lat);
        end
        total++;
        if (busy_ok !== 1'b1) begin
            bad++;
            $display("FAIL sin750_in_ready: in_ready rose while busy");
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        bit          stable;
        do_request(10'd30, 2'b00, 1'b0, d, q, e, lat, busy_ok, to);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || out_data !== 64'h3FE0_0000_0000_0000 ||
                out_quadrant !== 2'd0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
                stable = 1'b0;
            end
        end
        total++;
        if (to !== 1'b0 || stable !== 1'b1) begin
            bad++;
            $display("FAIL hold_stable: got data=%h valid=%b in_ready=%b want held result",
                     out_data, out_valid, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL release_in_ready: got in_ready=%b out_valid=%b want 1 0",
                     in_ready, out_valid);
        end
        do_request(10'd60, 2'b01, 1'b1, d, q, e, lat, busy_ok, to);
        total++;
        if (to !== 1'b0 || d !== 64'h3FE0_0000_0000_0000 || lat != 4) begin
            bad++;
            $display("FAIL b2b_cos60: got %h lat=%0d want 3fe0000000000000 lat=4", d, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] d;
        logic [1:0]  q;
        logic        e;
        int          lat;
        bit          busy_ok, to;
        bit          seen;
        in_valid = 1'b1;
        in_angle = 10'd1000;
        in_mode  = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_output: got out_valid=1 want 0 after mid-op reset");
        end
        total++;
        if (in_ready !== 1'b1 || out_data !== 64'h0) begin
            bad++;
            $display("FAIL abort_idle: got in_ready=%b data=%h want 1 0", in_ready, out_data);
        end
        do_request(10'd0, 2'b01, 1'b1, d, q, e, lat, busy_ok, to);
        total++;
        if (to !== 1'b0 || d !== 64'h3FF0_0000_0000_0000 || q !== 2'd0 || e !== 1'b0) begin
            bad++;
            $display("FAIL cos0_result: got %h q=%0d err=%b want 3ff0000000000000 q=0 err=0",
                     d, q, e);
        end
`ifdef TRIG_LUT_STATS_EN
        total++;
        if (op_count !== 32'd1 || err_count !== 16'd0) begin
            bad++;
            $display("FAIL stats_after_reset: got op=%0d err=%0d want op=1 err=0",
                     op_count, err_count);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sin30();
        test_quadrants();
        test_tan_pole();
        test_multi_wrap();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
